ddr2_traffic_gen: RTL and testbench
===================================

DDR2_TRAFFIC_GEN -- requirements
Module: ddr2_traffic_gen

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 25, width of ADDR/RADDR/BASE_ADDR.
- DATA_W, 16, width of DIN/DOUT/SEED.
- NBLK_W, 8, width of NUM_BLK.
- TIMEOUT, 4096, idle cycles in WAIT_RD before abort.
REQ-002 Ports SHALL be, one per line:
- CLK  in  1  single clock, all state on posedge.
- RESET  in  1  asynchronous, active-high reset.
- READY  in  1  controller initialised.
- START  in  1  one-cycle run request.
- MODE  in  2  data pattern select.
- SEED  in  DATA_W  pattern seed.
- BASE_ADDR  in  ADDR_W  first word address.
- NUM_BLK  in  NBLK_W  blocks per phase; 0 is treated as 1.
- SZ_CFG  in  2  block size code.
- NOTFULL  in  1  controller can accept a beat this cycle.
- DOUT  in  DATA_W  read data.
- RADDR  in  ADDR_W  read data address.
- VALIDOUT  in  1  DOUT/RADDR valid.
- CMD  out  3  command.
- SZ  out  2  size code to controller.
- OP  out  3  always 3'b000.
- FETCHING  out  1  DIN beat valid.
- DIN  out  DATA_W  write data.
- ADDR  out  ADDR_W  command address.
- BUSY  out  1  run in progress.
- DONE  out  1  run finished, held until next START.
- PASS  out  1  valid when DONE: ERR_CNT==0 and no timeout.
- TIMEOUT_FLAG  out  1  run aborted by timeout.
- ERR_CNT  out  16  miscompare count, saturating.
- FIRST_ERR_ADDR  out  ADDR_W  RADDR of first miscompare.

Function
REQ-003 CMD encoding SHALL be NOP=000, BLR=011, BLW=100; block length L = 8<<SZ_CFG words (8/16/32/64).
REQ-004 START, MODE, SEED, BASE_ADDR, NUM_BLK and SZ_CFG SHALL be sampled on a START cycle only when READY=1 and BUSY=0; START is ignored otherwise.
REQ-005 Block k (0..NUM_BLK-1) base address SHALL be BASE_ADDR + k*L, modulo 2^ADDR_W (wrap permitted).
REQ-006 Pattern for word address a SHALL be: MODE0 a[DATA_W-1:0]; MODE1 ~a[DATA_W-1:0]; MODE2 a[DATA_W-1:0]^SEED; MODE3 SEED rotated left by a[3:0].
REQ-007 FSM states SHALL be IDLE, WR_BEAT, RD_CMD, WAIT_RD, FIN; IDLE->WR_BEAT on accepted START.
REQ-008 WR_BEAT: FETCHING=1, DIN=pattern(current word address); first beat of a block also drives CMD=BLW, ADDR=block base, SZ=SZ_CFG; later beats drive CMD=NOP.
REQ-009 A beat/command SHALL be accepted only on a cycle with NOTFULL=1; with NOTFULL=0 all outputs hold unchanged.
REQ-010 After the last beat of the last block accepted -> RD_CMD; RD_CMD drives CMD=BLR, ADDR=block base, SZ=SZ_CFG for one accepted cycle per block, then -> WAIT_RD.
REQ-011 In non-issuing cycles CMD=NOP, FETCHING=0.
REQ-012 Every VALIDOUT cycle in RD_CMD or WAIT_RD SHALL compare DOUT to pattern(RADDR); a mismatch increments ERR_CNT (saturate at 16'hFFFF) and, if first, loads FIRST_ERR_ADDR.
REQ-013 Received-beat counter SHALL reach NUM_BLK*L -> FIN; VALIDOUT in IDLE/FIN SHALL be ignored.
REQ-014 In WAIT_RD a timer SHALL reset on each VALIDOUT and on reaching TIMEOUT set TIMEOUT_FLAG -> FIN.
REQ-015 FIN SHALL set DONE=1, BUSY=0, PASS=(ERR_CNT==0 && !TIMEOUT_FLAG) one cycle after entry and return to IDLE; a new accepted START clears DONE, PASS, TIMEOUT_FLAG, ERR_CNT, FIRST_ERR_ADDR.
REQ-016 BUSY SHALL be 1 in WR_BEAT, RD_CMD, WAIT_RD.

Reset
REQ-017 RESET=1 SHALL asynchronously force IDLE, CMD=NOP, SZ=0, OP=0, FETCHING=0, DIN=0, ADDR=0, BUSY=0, DONE=0, PASS=0, TIMEOUT_FLAG=0, ERR_CNT=0, FIRST_ERR_ADDR=0, all counters 0.
REQ-018 RESET mid-run SHALL abort immediately; no further commands until a new accepted START.

Verification
REQ-019 Directed scenarios:
- MODE0, NUM_BLK=2, SZ_CFG=0, BASE=0x100, NOTFULL=1, ideal echo -> BLW at 0x100/0x108, 16 FETCHING beats, BLR at 0x100/0x108, DONE=1, PASS=1, ERR_CNT=0.
- As above, NOTFULL toggled 0/1 each cycle -> identical beat sequence, outputs stable during NOTFULL=0.
- MODE2 SEED=0xA5A5, one returned word at RADDR 0x104 corrupted -> ERR_CNT=1, FIRST_ERR_ADDR=0x104, PASS=0.
- BASE=0x1FFFFFC, SZ_CFG=0, NUM_BLK=1 -> word addresses wrap 0x1FFFFFF->0x0000000, second block base 0x0000004 when NUM_BLK=2.
- Controller returns no read data -> TIMEOUT_FLAG=1 after 4096 cycles in WAIT_RD, DONE=1, PASS=0.
- START while READY=0, and RESET asserted mid-WR_BEAT -> no commands issued; all outputs at reset values.

Source files
------------

// File: rtl/ddr2_traffic_gen.sv
`timescale 1ns/1ps
// ddr2_traffic_gen
// Write-then-read-back exerciser for a DDR2 memory controller. A run writes
// NUM_BLK blocks of L = 8<<SZ_CFG words starting at BASE_ADDR with a
// selectable data pattern. It then issues one block-read command per block
// and checks every returned word against the pattern expected at its address.
//
// Ports
//   CLK, RESET        clock (posedge) and asynchronous active-high reset
//   READY             controller initialised; START is honoured only then
//   START             one-cycle run request (sampled with MODE, SEED,
//                     BASE_ADDR, NUM_BLK, SZ_CFG when idle)
//   NOTFULL           controller consumes the presented beat/command
//   DOUT/RADDR/       read data, its word address and its valid strobe
//   VALIDOUT
//   CMD/SZ/OP/ADDR    command to the controller (NOP=000, BLR=011, BLW=100)
//   FETCHING/DIN      write-data beat valid and data
//   BUSY/DONE/PASS    run status; DONE and PASS are held until the next START
//   TIMEOUT_FLAG      read data stopped arriving for TIMEOUT cycles
//   ERR_CNT           saturating miscompare count
//   FIRST_ERR_ADDR    RADDR of the first miscompare of the run
//
// Handshake: a command and/or write beat sits on the registered outputs and
// is consumed on the rising edge where NOTFULL=1. While NOTFULL=0 every
// command-side output holds its value. Read data has no back-pressure: each
// cycle with VALIDOUT=1 carries one word.

module ddr2_traffic_gen #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int NBLK_W  = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READY,
    input  logic              START,
    input  logic [1:0]        MODE,
    input  logic [DATA_W-1:0] SEED,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [NBLK_W-1:0] NUM_BLK,
    input  logic [1:0]        SZ_CFG,
    input  logic              NOTFULL,
    input  logic [DATA_W-1:0] DOUT,
    input  logic [ADDR_W-1:0] RADDR,
    input  logic              VALIDOUT,
    output logic [2:0]        CMD,
    output logic [1:0]        SZ,
    output logic [2:0]        OP,
    output logic              FETCHING,
    output logic [DATA_W-1:0] DIN,
    output logic [ADDR_W-1:0] ADDR,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic              TIMEOUT_FLAG,
    output logic [15:0]       ERR_CNT,
    output logic [ADDR_W-1:0] FIRST_ERR_ADDR
);

    localparam logic [2:0] CMD_NOP = 3'b000;
    localparam logic [2:0] CMD_BLR = 3'b011;
    localparam logic [2:0] CMD_BLW = 3'b100;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W = NBLK_W + 7;   // holds NUM_BLK * 64

    typedef enum logic [2:0] {S_IDLE, S_WR_BEAT, S_RD_CMD, S_WAIT_RD, S_FIN} state_t;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        mode,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] seed);
        logic [2*DATA_W-1:0] rot;
        // Upper half of the doubled seed shifted left is the rotate-left result.
        rot = {seed, seed} << a[3:0];
        case (mode)
            2'd0:    pattern = a[DATA_W-1:0];
            2'd1:    pattern = ~a[DATA_W-1:0];
            2'd2:    pattern = a[DATA_W-1:0] ^ seed;
            default: pattern = rot[2*DATA_W-1:DATA_W];
        endcase
    endfunction

    function automatic logic [5:0] last_beat(input logic [1:0] sz);
        last_beat = 6'((7'd8 << sz) - 7'd1);
    endfunction

    state_t              state_q, state_d;
    logic [2:0]          cmd_q, cmd_d;
    logic [1:0]          sz_q, sz_d;
    logic                fetching_q, fetching_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                tmo_q, tmo_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [NBLK_W-1:0]   last_blk_q, last_blk_d;
    logic [NBLK_W-1:0]   blk_q, blk_d;
    logic [5:0]          beat_q, beat_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [CNT_W-1:0]    rx_q, rx_d;
    logic [CNT_W-1:0]    total_q, total_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;

    logic [NBLK_W-1:0]   nblk_eff;
    logic [ADDR_W-1:0]   blk_step;
    logic [ADDR_W-1:0]   waddr_inc;
    logic                rx_done;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        sz_d        = sz_q;
        fetching_d  = fetching_q;
        din_d       = din_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        tmo_d       = tmo_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        mode_d      = mode_q;
        seed_d      = seed_q;
        base_d      = base_q;
        last_blk_d  = last_blk_q;
        blk_d       = blk_q;
        beat_d      = beat_q;
        waddr_d     = waddr_q;
        rx_d        = rx_q;
        total_d     = total_q;
        tmr_d       = tmr_q;
        rx_done     = 1'b0;
        nblk_eff    = (NUM_BLK == '0) ? NBLK_W'(1) : NUM_BLK;
        blk_step    = ADDR_W'(last_beat(sz_q)) + ADDR_W'(1);
        waddr_inc   = waddr_q + ADDR_W'(1);

        // Read-data checking runs alongside command issue, since data for
        // early blocks can return while later BLR commands are still queued.
        if ((state_q == S_RD_CMD || state_q == S_WAIT_RD) && VALIDOUT) begin
            rx_d    = rx_q + CNT_W'(1);
            rx_done = (rx_d == total_q);
            if (DOUT != pattern(mode_q, RADDR, seed_q)) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                if (err_cnt_q == 16'd0)    first_err_d = RADDR;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (START && READY && !busy_q) begin
                    state_d     = S_WR_BEAT;
                    mode_d      = MODE;
                    seed_d      = SEED;
                    base_d      = BASE_ADDR;
                    last_blk_d  = nblk_eff - NBLK_W'(1);
                    total_d     = CNT_W'(nblk_eff) << (3'd3 + {1'b0, SZ_CFG});
                    blk_d       = '0;
                    beat_d      = '0;
                    waddr_d     = BASE_ADDR;
                    rx_d        = '0;
                    tmr_d       = '0;
                    cmd_d       = CMD_BLW;
                    addr_d      = BASE_ADDR;
                    sz_d        = SZ_CFG;
                    fetching_d  = 1'b1;
                    din_d       = pattern(MODE, BASE_ADDR, SEED);
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    tmo_d       = 1'b0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                end
            end
            S_WR_BEAT: begin
                if (NOTFULL) begin
                    waddr_d = waddr_inc;
                    if (beat_q != last_beat(sz_q)) begin
                        beat_d = beat_q + 6'd1;
                        cmd_d  = CMD_NOP;
                        din_d  = pattern(mode_q, waddr_inc, seed_q);
                    end else if (blk_q != last_blk_q) begin
                        // Blocks are contiguous, so the next block base is
                        // simply the next word address (wrapping naturally).
                        beat_d = '0;
                        blk_d  = blk_q + NBLK_W'(1);
                        cmd_d  = CMD_BLW;
                        addr_d = waddr_inc;
                        din_d  = pattern(mode_q, waddr_inc, seed_q);
                    end else begin
                        state_d    = S_RD_CMD;
                        blk_d      = '0;
                        cmd_d      = CMD_BLR;
                        addr_d     = base_q;
                        fetching_d = 1'b0;
                    end
                end
            end
            S_RD_CMD: begin
                if (rx_done) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    cmd_d   = CMD_NOP;
                end else if (NOTFULL) begin
                    if (blk_q != last_blk_q) begin
                        blk_d  = blk_q + NBLK_W'(1);
                        addr_d = addr_q + blk_step;
                    end else begin
                        state_d = S_WAIT_RD;
                        cmd_d   = CMD_NOP;
                    end
                end
            end
            S_WAIT_RD: begin
                if (rx_done) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                end else if (VALIDOUT) begin
                    tmr_d = '0;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    tmo_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_FIN: begin
                // err_cnt_q and tmo_q are final here: the last read word or
                // the timeout was registered on the edge that entered FIN.
                done_d  = 1'b1;
                pass_d  = (err_cnt_q == 16'd0) && !tmo_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cmd_q       <= CMD_NOP;
            sz_q        <= '0;
            fetching_q  <= 1'b0;
            din_q       <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            tmo_q       <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            mode_q      <= '0;
            seed_q      <= '0;
            base_q      <= '0;
            last_blk_q  <= '0;
            blk_q       <= '0;
            beat_q      <= '0;
            waddr_q     <= '0;
            rx_q        <= '0;
            total_q     <= '0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            sz_q        <= sz_d;
            fetching_q  <= fetching_d;
            din_q       <= din_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            tmo_q       <= tmo_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            mode_q      <= mode_d;
            seed_q      <= seed_d;
            base_q      <= base_d;
            last_blk_q  <= last_blk_d;
            blk_q       <= blk_d;
            beat_q      <= beat_d;
            waddr_q     <= waddr_d;
            rx_q        <= rx_d;
            total_q     <= total_d;
            tmr_q       <= tmr_d;
        end
    end

    assign CMD            = cmd_q;
    assign SZ             = sz_q;
    assign OP             = 3'b000;
    assign FETCHING       = fetching_q;
    assign DIN            = din_q;
    assign ADDR           = addr_q;
    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign PASS           = pass_q;
    assign TIMEOUT_FLAG   = tmo_q;
    assign ERR_CNT        = err_cnt_q;
    assign FIRST_ERR_ADDR = first_err_q;

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
`timescale 1ns/1ps
// Bench for ddr2_traffic_gen: an echo-memory controller model stores written
// beats and returns them for each BLR; run-level results come from a table of
// hand-computed vectors, and reset / READY / timeout cases are hand sequences.
module tb_ddr2_traffic_gen;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int NBLK_W = 8;
    localparam logic [2:0] NOP = 3'b000;
    localparam logic [2:0] BLR = 3'b011;
    localparam logic [2:0] BLW = 3'b100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic              READY, START, NOTFULL, VALIDOUT;
    logic [1:0]        MODE, SZ_CFG;
    logic [DATA_W-1:0] SEED, DOUT;
    logic [ADDR_W-1:0] BASE_ADDR, RADDR;
    logic [NBLK_W-1:0] NUM_BLK;
    logic [2:0]        CMD, OP;
    logic [1:0]        SZ;
    logic              FETCHING, BUSY, DONE, PASS, TIMEOUT_FLAG;
    logic [DATA_W-1:0] DIN;
    logic [ADDR_W-1:0] ADDR, FIRST_ERR_ADDR;
    logic [15:0]       ERR_CNT;

    ddr2_traffic_gen dut (
        .CLK(clk), .RESET(rst), .READY(READY), .START(START), .MODE(MODE),
        .SEED(SEED), .BASE_ADDR(BASE_ADDR), .NUM_BLK(NUM_BLK), .SZ_CFG(SZ_CFG),
        .NOTFULL(NOTFULL), .DOUT(DOUT), .RADDR(RADDR), .VALIDOUT(VALIDOUT),
        .CMD(CMD), .SZ(SZ), .OP(OP), .FETCHING(FETCHING), .DIN(DIN), .ADDR(ADDR),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .TIMEOUT_FLAG(TIMEOUT_FLAG),
        .ERR_CNT(ERR_CNT), .FIRST_ERR_ADDR(FIRST_ERR_ADDR)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0]   exp_q[$];
    logic [ADDR_W+2:0]   exp_cmd_q[$];
    logic [ADDR_W-1:0]   rd_pend[$];
    logic [DATA_W-1:0]   mem [logic [ADDR_W-1:0]];
    logic [ADDR_W-1:0]   wr_ptr = '0;
    logic [ADDR_W-1:0]   last_blw = '0;
    int                  beats_seen = 0;
    int                  blr_done_cyc = 0;
    bit                  nf_toggle = 1'b0;
    bit                  no_reply = 1'b0;
    bit                  bad_en = 1'b0;
    logic [ADDR_W-1:0]   bad_a = '0, bad_b = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string info);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s", name, info);
    endtask

    function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                                              input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        r = s;
        for (int i = 0; i < int'(a[3:0]); i++) r = {r[DATA_W-2:0], r[DATA_W-1]};
        case (m)
            2'd0:    return a[DATA_W-1:0];
            2'd1:    return ~a[DATA_W-1:0];
            2'd2:    return a[DATA_W-1:0] ^ s;
            default: return r;
        endcase
    endfunction

    // Monitor: sample at negedge; a beat/command counts when NOTFULL=1.
    initial begin
        logic [ADDR_W+DATA_W+5:0] prev_out, cur_out;
        logic [ADDR_W+2:0]        e;
        logic [ADDR_W-1:0]        ra;
        logic                     prev_nf, prev_busy;
        prev_out = '0; prev_nf = 1'b1; prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            cur_out = {CMD, SZ, FETCHING, DIN, ADDR};
            if (!rst) begin
                if (!prev_nf && prev_busy && BUSY) check("hold_when_notfull0", cur_out, prev_out);
                if (NOTFULL && CMD != NOP) begin
                    if (exp_cmd_q.size() == 0) begin
                        fail_now("unexpected_cmd", $sformatf("got CMD=%0h ADDR=0x%0h, required none", CMD, ADDR));
                    end else begin
                        e = exp_cmd_q.pop_front();
                        check("cmd_addr", {CMD, ADDR}, e);
                        if (CMD == BLR && exp_cmd_q.size() == 0) blr_done_cyc = cyc;
                    end
                    if (CMD == BLW) begin
                        wr_ptr   = ADDR;
                        last_blw = ADDR;
                    end
                    if (CMD == BLR) begin
                        for (int i = 0; i < (8 << SZ); i++) begin
                            ra = ADDR + ADDR_W'(i);
                            rd_pend.push_back(ra);
                        end
                    end
                end
                if (NOTFULL && FETCHING) begin
                    beats_seen++;
                    if (exp_q.size() == 0) fail_now("unexpected_beat", $sformatf("got DIN=0x%0h, required none", DIN));
                    else check("din", DIN, exp_q.pop_front());
                    mem[wr_ptr] = DIN;
                    wr_ptr = wr_ptr + ADDR_W'(1);
                end
            end
            prev_out  = cur_out;
            prev_nf   = NOTFULL;
            prev_busy = BUSY && !rst;
        end
    end

    // Controller model: NOTFULL pacing and one read word per cycle.
    initial begin
        logic [ADDR_W-1:0] a;
        NOTFULL = 1'b1; VALIDOUT = 1'b0; DOUT = '0; RADDR = '0;
        forever begin
            @(posedge clk); #1;
            NOTFULL = nf_toggle ? ~NOTFULL : 1'b1;
            if (!no_reply && rd_pend.size() > 0) begin
                a = rd_pend.pop_front();
                RADDR = a;
                DOUT  = mem.exists(a) ? mem[a] : '0;
                if (bad_en && (a == bad_a || a == bad_b)) DOUT = DOUT ^ 16'h0100;
                VALIDOUT = 1'b1;
            end else begin
                VALIDOUT = 1'b0;
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic [1:0]        mode;
        logic [DATA_W-1:0] seed;
        logic [ADDR_W-1:0] base;
        logic [NBLK_W-1:0] nblk;
        logic [1:0]        sz;
        bit                nf_toggle;
        bit                no_reply;
        bit                bad_en;
        logic [ADDR_W-1:0] bad_a;
        logic [ADDR_W-1:0] bad_b;
        logic [15:0]       exp_err;
        logic [ADDR_W-1:0] exp_first;
        bit                exp_pass;
        bit                exp_tmo;
        int                exp_beats;
        logic [ADDR_W-1:0] exp_last_blw;
    } vec_t;

    task automatic start_run(input vec_t v);
        int nb, len;
        logic [ADDR_W-1:0] b, wa;
        exp_q.delete(); exp_cmd_q.delete(); rd_pend.delete(); mem.delete();
        beats_seen = 0;
        nf_toggle = v.nf_toggle; no_reply = v.no_reply;
        bad_en = v.bad_en; bad_a = v.bad_a; bad_b = v.bad_b;
        nb  = (v.nblk == 0) ? 1 : int'(v.nblk);
        len = 8 << v.sz;
        for (int k = 0; k < nb; k++) begin
            b = v.base + ADDR_W'(k * len);
            exp_cmd_q.push_back({BLW, b});
            for (int w = 0; w < len; w++) begin
                wa = b + ADDR_W'(w);
                exp_q.push_back(pat(v.mode, wa, v.seed));
            end
        end
        for (int k = 0; k < nb; k++) begin
            b = v.base + ADDR_W'(k * len);
            exp_cmd_q.push_back({BLR, b});
        end
        MODE = v.mode; SEED = v.seed; BASE_ADDR = v.base; NUM_BLK = v.nblk; SZ_CFG = v.sz;
        START = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (DONE) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        int done_cyc;
        start_run(v);
        wait_done(6000, ok);
        done_cyc = cyc;
        nf_toggle = 1'b0;
        if (!ok) begin
            fail_now($sformatf("v%0d_done_wait", idx), "DONE never rose within 6000 cycles, required 1");
        end else begin
            check($sformatf("v%0d_busy", idx), BUSY, 0);
            check($sformatf("v%0d_pass", idx), PASS, v.exp_pass);
            check($sformatf("v%0d_tmo", idx), TIMEOUT_FLAG, v.exp_tmo);
            check($sformatf("v%0d_err_cnt", idx), ERR_CNT, v.exp_err);
            check($sformatf("v%0d_first_err", idx), FIRST_ERR_ADDR, v.exp_first);
            check($sformatf("v%0d_beats", idx), beats_seen, v.exp_beats);
            check($sformatf("v%0d_last_blw", idx), last_blw, v.exp_last_blw);
            check($sformatf("v%0d_cmds_left", idx), exp_cmd_q.size(), 0);
            check($sformatf("v%0d_beats_left", idx), exp_q.size(), 0);
            if (v.exp_tmo) check($sformatf("v%0d_done_latency", idx), done_cyc - blr_done_cyc, 4098);
            @(negedge clk);
            check($sformatf("v%0d_done_held", idx), DONE, 1);
        end
        rd_pend.delete();
        no_reply = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd"}, CMD, 0);
        check({tag, "_sz"}, SZ, 0);
        check({tag, "_op"}, OP, 0);
        check({tag, "_fetching"}, FETCHING, 0);
        check({tag, "_din"}, DIN, 0);
        check({tag, "_addr"}, ADDR, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_done"}, DONE, 0);
        check({tag, "_pass"}, PASS, 0);
        check({tag, "_tmo"}, TIMEOUT_FLAG, 0);
        check({tag, "_err_cnt"}, ERR_CNT, 0);
        check({tag, "_first_err"}, FIRST_ERR_ADDR, 0);
    endtask

    // ---------------- main test ----------------
    initial begin
        vec_t vecs[9];
        int   bsnap;
        bit   ok;

        //          mode  seed      base          nblk  sz  tog nr bad bad_a         bad_b         err    first         pass tmo beats last_blw
        vecs[0] = '{2'd0, 16'h0000, 25'h0000100, 8'd2, 2'd0, 0, 0, 0, 25'h0,        25'h0,        16'd0, 25'h0,        1, 0, 16, 25'h0000108};
        vecs[1] = '{2'd0, 16'h0000, 25'h0000100, 8'd2, 2'd0, 1, 0, 0, 25'h0,        25'h0,        16'd0, 25'h0,        1, 0, 16, 25'h0000108};
        vecs[2] = '{2'd2, 16'hA5A5, 25'h0000100, 8'd2, 2'd0, 0, 0, 1, 25'h0000104, 25'h0000104, 16'd1, 25'h0000104, 0, 0, 16, 25'h0000108};
        vecs[3] = '{2'd1, 16'h0000, 25'h1FFFFFC, 8'd1, 2'd0, 0, 0, 0, 25'h0,        25'h0,        16'd0, 25'h0,        1, 0,  8, 25'h1FFFFFC};
        vecs[4] = '{2'd3, 16'h1234, 25'h1FFFFFC, 8'd2, 2'd0, 0, 0, 0, 25'h0,        25'h0,        16'd0, 25'h0,        1, 0, 16, 25'h0000004};
        vecs[5] = '{2'd0, 16'h0000, 25'h0000020, 8'd0, 2'd1, 0, 0, 0, 25'h0,        25'h0,        16'd0, 25'h0,        1, 0, 16, 25'h0000020};
        vecs[6] = '{2'd2, 16'hFFFF, 25'h0000200, 8'd1, 2'd3, 1, 0, 1, 25'h0000210, 25'h0000230, 16'd2, 25'h0000210, 0, 0, 64, 25'h0000200};
        vecs[7] = '{2'd0, 16'h0000, 25'h0000300, 8'd1, 2'd0, 0, 1, 0, 25'h0,        25'h0,        16'd0, 25'h0,        0, 1,  8, 25'h0000300};
        vecs[8] = '{2'd1, 16'h0000, 25'h0000040, 8'd3, 2'd2, 0, 0, 0, 25'h0,        25'h0,        16'd0, 25'h0,        1, 0, 96, 25'h0000080};

        rst = 1'b1; READY = 1'b0; START = 1'b0; MODE = '0; SEED = '0;
        BASE_ADDR = '0; NUM_BLK = '0; SZ_CFG = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // START while READY=0 must be ignored.
        START = 1'b1;
        @(posedge clk); #1;
        START = 1'b0;
        repeat (10) @(negedge clk);
        check("ready0_busy", BUSY, 0);
        check("ready0_cmd", CMD, NOP);
        check("ready0_beats", beats_seen, 0);
        READY = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // RESET in the middle of the write phase.
        start_run(vecs[0]);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (beats_seen >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("midrun_wait", "fewer than 3 beats within 50 cycles, required 3");
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete(); exp_cmd_q.delete(); rd_pend.delete();
        bsnap = beats_seen;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        check_reset_outputs("post_rst");
        check("post_rst_beats", beats_seen, bsnap);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
